warrior_sprite_ctrl: RTL and testbench

Controls the overworld warrior sprite and feeds the sprite-ROM modules. It holds the sprite position, facing direction and walk-animation frame, and moves the sprite once per video frame from the button inputs. Each cycle it converts the VGA raster coordinate into a ROM pixel index and returns a registered color and draw-enable to the pixel mux. It sits between the VGA timing generator and the set of direction/frame sprite ROMs (Left1/Left2, Right1/Right2, and so on).

---
 rtl/warrior_pkg.sv | 30 +++
 rtl/warrior_anim_fsm.sv | 116 +++++++++++
 rtl/warrior_sprite_ctrl.sv | 101 ++++++++++
 tb/tb_warrior_sprite_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/warrior_pkg.sv
// Shared types, constants and helpers for the overworld warrior sprite controller.
package warrior_pkg;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned EXT_W   = 9;
    localparam int unsigned PIX_W   = 17;
    localparam int unsigned COLOR_W = 16;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned CALC_W  = 11;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    localparam logic [COLOR_W-1:0] TRANSPARENT = 16'hffff;

    // ROM select is {direction, animation frame}
    function automatic logic [SEL_W-1:0] pack_sprite_sel(input dir_t d, input logic frame);
        return {d, frame};
    endfunction

endpackage

// File: rtl/warrior_anim_fsm.sv
// Per-frame sprite state: walk/idle FSM, facing direction, animation frame and clamped position.
module warrior_anim_fsm
    import warrior_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned START_X     = 304,
    parameter int unsigned START_Y     = 224,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned STEP_FRAMES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_frame_tick,
    input  logic             i_btn_left,
    input  logic             i_btn_right,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    input  logic [EXT_W-1:0] i_rom_width,
    input  logic [EXT_W-1:0] i_rom_height,
    output logic [POS_W-1:0] o_pos_x,
    output logic [POS_W-1:0] o_pos_y,
    output dir_t             o_dir,
    output logic             o_anim_frame
);

    localparam int unsigned      CNT_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CALC_W-1:0] SPEED_C = CALC_W'(SPEED);
    localparam logic [CALC_W-1:0] X_MAX   = CALC_W'(H_ACTIVE - 1);
    localparam logic [CALC_W-1:0] Y_MAX   = CALC_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_FRAMES - 1);

    state_t            r_state, w_state_nxt;
    dir_t              r_dir, w_dir_nxt, w_dir_req;
    logic [POS_W-1:0]  r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_anim, w_anim_nxt;
    logic              w_any_btn;
    logic [CALC_W-1:0] w_x_inc, w_y_inc, w_x_lim, w_y_lim;

    assign w_any_btn = i_btn_left | i_btn_right | i_btn_up | i_btn_down;

    // 11-bit arithmetic so the right/down clamp never sees a wrapped sum
    assign w_x_inc = CALC_W'(r_pos_x) + SPEED_C;
    assign w_y_inc = CALC_W'(r_pos_y) + SPEED_C;
    assign w_x_lim = X_MAX - CALC_W'(i_rom_width);
    assign w_y_lim = Y_MAX - CALC_W'(i_rom_height);

    always_comb begin
        w_dir_req = DOWN;
        if (i_btn_left)       w_dir_req = LEFT;
        else if (i_btn_right) w_dir_req = RIGHT;
        else if (i_btn_up)    w_dir_req = UP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_frame_tick) w_state_nxt = w_any_btn ? WALK : IDLE;
    end

    // A walking tick moves, turns and advances the step counter in one go
    always_comb begin
        w_dir_nxt   = r_dir;
        w_pos_x_nxt = r_pos_x;
        w_pos_y_nxt = r_pos_y;
        w_cnt_nxt   = r_cnt;
        w_anim_nxt  = r_anim;
        if (i_frame_tick) begin
            if (w_state_nxt == WALK) begin
                w_dir_nxt = w_dir_req;
                case (w_dir_req)
                    LEFT:  w_pos_x_nxt = (CALC_W'(r_pos_x) < SPEED_C) ? '0 : r_pos_x - POS_W'(SPEED);
                    RIGHT: w_pos_x_nxt = (w_x_inc > w_x_lim) ? POS_W'(w_x_lim) : POS_W'(w_x_inc);
                    UP:    w_pos_y_nxt = (CALC_W'(r_pos_y) < SPEED_C) ? '0 : r_pos_y - POS_W'(SPEED);
                    DOWN:  w_pos_y_nxt = (w_y_inc > w_y_lim) ? POS_W'(w_y_lim) : POS_W'(w_y_inc);
                endcase
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt  = '0;
                    w_anim_nxt = ~r_anim;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end else if (r_state == WALK) begin
                w_cnt_nxt  = '0;
                w_anim_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir   <= LEFT;
            r_pos_x <= POS_W'(START_X);
            r_pos_y <= POS_W'(START_Y);
            r_cnt   <= '0;
            r_anim  <= 1'b0;
        end else begin
            r_dir   <= w_dir_nxt;
            r_pos_x <= w_pos_x_nxt;
            r_pos_y <= w_pos_y_nxt;
            r_cnt   <= w_cnt_nxt;
            r_anim  <= w_anim_nxt;
        end
    end

    assign o_pos_x      = r_pos_x;
    assign o_pos_y      = r_pos_y;
    assign o_dir        = r_dir;
    assign o_anim_frame = r_anim;

endmodule

// File: rtl/warrior_sprite_ctrl.sv
// Warrior sprite controller: per-frame movement plus a 2-cycle raster-to-ROM-to-color pipeline.
module warrior_sprite_ctrl
    import warrior_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned START_X     = 304,
    parameter int unsigned START_Y     = 224,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned STEP_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic [POS_W-1:0]   hcount,
    input  logic [POS_W-1:0]   vcount,
    input  logic [EXT_W-1:0]   rom_width,
    input  logic [EXT_W-1:0]   rom_height,
    input  logic [COLOR_W-1:0] rom_color,
    output logic [PIX_W-1:0]   pixel,
    output logic [SEL_W-1:0]   sprite_sel,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic               draw_en,
    output logic [COLOR_W-1:0] color_out
);

    logic [POS_W-1:0]   w_pos_x, w_pos_y, w_dh, w_dv;
    dir_t               w_dir;
    logic               w_anim;
    logic               w_in_box, w_opaque;
    logic [PIX_W-1:0]   w_pixel_idx;
    logic [PIX_W-1:0]   r_pixel;
    logic               r_in_box_d;
    logic               r_draw_en;
    logic [COLOR_W-1:0] r_color;

    warrior_anim_fsm #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .START_X     (START_X),
        .START_Y     (START_Y),
        .SPEED       (SPEED),
        .STEP_FRAMES (STEP_FRAMES)
    ) u_anim_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (frame_tick),
        .i_btn_left   (btn_left),
        .i_btn_right  (btn_right),
        .i_btn_up     (btn_up),
        .i_btn_down   (btn_down),
        .i_rom_width  (rom_width),
        .i_rom_height (rom_height),
        .o_pos_x      (w_pos_x),
        .o_pos_y      (w_pos_y),
        .o_dir        (w_dir),
        .o_anim_frame (w_anim)
    );

    // Offsets are only meaningful once the raster is at or past the top-left corner
    assign w_dh     = hcount - w_pos_x;
    assign w_dv     = vcount - w_pos_y;
    assign w_in_box = (hcount >= w_pos_x) && (vcount >= w_pos_y) &&
                      (w_dh <= POS_W'(rom_width)) && (w_dv <= POS_W'(rom_height));
    assign w_pixel_idx = PIX_W'(w_dv) * (PIX_W'(rom_width) + PIX_W'(1)) + PIX_W'(w_dh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel    <= '0;
            r_in_box_d <= 1'b0;
        end else begin
            r_pixel    <= w_in_box ? w_pixel_idx : '0;
            r_in_box_d <= w_in_box;
        end
    end

    assign w_opaque = r_in_box_d && (rom_color != TRANSPARENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_draw_en <= 1'b0;
            r_color   <= '0;
        end else begin
            r_draw_en <= w_opaque;
            r_color   <= w_opaque ? rom_color : '0;
        end
    end

    assign pixel      = r_pixel;
    assign draw_en    = r_draw_en;
    assign color_out  = r_color;
    assign pos_x      = w_pos_x;
    assign pos_y      = w_pos_y;
    assign sprite_sel = pack_sprite_sel(w_dir, w_anim);

endmodule

// File: tb/tb_warrior_sprite_ctrl.sv
// Scoreboard bench for warrior_sprite_ctrl: driver queues expectations, negedge monitor compares.
module tb_warrior_sprite_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [9:0]  hcount = '0, vcount = '0;
    logic [8:0]  rom_width = 9'd33, rom_height = 9'd40;
    logic [15:0] rom_color = 16'h2082;
    logic [16:0] pixel;
    logic [2:0]  sprite_sel;
    logic [9:0]  pos_x, pos_y;
    logic        draw_en;
    logic [15:0] color_out;

    always #5 clk = ~clk;

    warrior_sprite_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .hcount     (hcount),
        .vcount     (vcount),
        .rom_width  (rom_width),
        .rom_height (rom_height),
        .rom_color  (rom_color),
        .pixel      (pixel),
        .sprite_sel (sprite_sel),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .draw_en    (draw_en),
        .color_out  (color_out)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] sel;
        logic [2:0] mask;
        logic       rst_chk;
    } st_exp_t;

    logic [16:0] pix_q[$];
    logic [16:0] drw_q[$];
    st_exp_t     st_q[$];
    logic        issue = 1'b0, v1 = 1'b0, v2 = 1'b0;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Bench-side valid pipeline tracks when an issued raster vector reaches each output stage
    always @(posedge clk) begin
        v1 <= issue;
        v2 <= v1;
    end

    always @(negedge clk) begin
        logic [16:0] e;
        st_exp_t     s;
        if (v1) begin
            if (pix_q.size() == 0) chk("pixel_queue_empty", 32'd1, 32'd0);
            else begin
                e = pix_q.pop_front();
                chk("pixel", 32'(pixel), 32'(e));
            end
        end
        if (v2) begin
            if (drw_q.size() == 0) chk("draw_queue_empty", 32'd1, 32'd0);
            else begin
                e = drw_q.pop_front();
                chk("draw_en", 32'(draw_en), 32'(e[16]));
                if (e[16]) chk("color_out", 32'(color_out), 32'(e[15:0]));
            end
        end
        if (st_q.size() != 0) begin
            s = st_q.pop_front();
            chk("pos_x", 32'(pos_x), 32'(s.x));
            chk("pos_y", 32'(pos_y), 32'(s.y));
            chk("sprite_sel", 32'(sprite_sel & s.mask), 32'(s.sel & s.mask));
            if (s.rst_chk) begin
                chk("rst_pixel", 32'(pixel), 32'd0);
                chk("rst_draw_en", 32'(draw_en), 32'd0);
                chk("rst_color_out", 32'(color_out), 32'd0);
            end
        end
    end

    task automatic raster(input int h, input int v, input logic [15:0] c,
                          input int exp_pix, input logic exp_draw);
        @(posedge clk); #1;
        hcount = 10'(h); vcount = 10'(v); rom_color = c; issue = 1'b1;
        pix_q.push_back(17'(exp_pix));
        drw_q.push_back({exp_draw, c});
        @(posedge clk); #1;
        issue = 1'b0;
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic tick(input logic l, input logic r, input logic u, input logic d);
        @(posedge clk); #1;
        btn_left = l; btn_right = r; btn_up = u; btn_down = d; frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic expect_st(input int x, input int y, input logic [2:0] sel,
                             input logic [2:0] mask, input logic rc);
        st_exp_t s;
        s.x = 10'(x); s.y = 10'(y); s.sel = sel; s.mask = mask; s.rst_chk = rc;
        st_q.push_back(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x, y;
        logic a;
        #12;
        expect_st(304, 224, 3'b000, 3'b111, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Raster index, transparency and box edges at the reset position
        raster(307, 226, 16'h2082,   71, 1'b1);
        raster(307, 226, 16'hffff,   71, 1'b0);
        raster(303, 226, 16'h2082,    0, 1'b0);
        raster(338, 226, 16'h2082,    0, 1'b0);
        raster(304, 224, 16'h1234,    0, 1'b1);
        raster(337, 264, 16'h07e0, 1393, 1'b1);
        raster(337, 265, 16'h07e0,    0, 1'b0);
        raster(304, 223, 16'h07e0,    0, 1'b0);

        // Walk right: frame toggles every 8 ticks
        for (int k = 1; k <= 26; k++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            a = ((k / 8) % 2) == 1;
            expect_st(304 + 2 * k, 224, {2'b01, a}, 3'b111, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_st(356, 224, 3'b010, 3'b111, 1'b0);

        // Counter restarts from zero after idle
        for (int j = 1; j <= 8; j++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            expect_st(356 + 2 * j, 224, {2'b01, (j == 8)}, 3'b111, 1'b0);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        expect_st(370, 224, 3'b001, 3'b111, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_st(370, 224, 3'b000, 3'b111, 1'b0);

        // Right clamp at 639-33
        for (int k = 1; k <= 125; k++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            x = 370 + 2 * k;
            if (x > 606) x = 606;
            expect_st(x, 224, 3'b010, 3'b110, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_st(606, 224, 3'b010, 3'b111, 1'b0);

        // Wider ROM pulls the clamp to an odd column, then walk left to zero
        @(posedge clk); #1;
        rom_width = 9'd34;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_st(605, 224, 3'b010, 3'b110, 1'b0);
        for (int k = 1; k <= 304; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            x = 605 - 2 * k;
            if (x < 0) x = 0;
            expect_st(x, 224, 3'b000, 3'b110, 1'b0);
        end

        // Down clamp at 479-40, then step up
        for (int k = 1; k <= 110; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            y = 224 + 2 * k;
            if (y > 439) y = 439;
            expect_st(0, y, 3'b110, 3'b110, 1'b0);
        end
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            expect_st(0, 439 - 2 * k, 3'b100, 3'b110, 1'b0);
        end

        // Opaque pixel on screen, then asynchronous reset while walking
        raster(5, 435, 16'h2082, 75, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        expect_st(304, 224, 3'b000, 3'b111, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_st(304, 224, 3'b000, 3'b111, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_st(304, 224, 3'b000, 3'b111, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", 32'(pix_q.size() + drw_q.size() + st_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
